// File: rtl/mag_seq_pkg.sv
// Shared encodings for the magnetometer poll sequencer: I2C byte-master ops, FSM states, script steps.
package mag_seq_pkg;

    localparam int unsigned STEP_W = 4;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_START   = 3'd0,
        OP_WRBYTE  = 3'd1,
        OP_RD_ACK  = 3'd2,
        OP_RD_NACK = 3'd3,
        OP_STOP    = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN_INIT  = 3'd1,
        ST_RUN_POLL  = 3'd2,
        ST_POLL_WAIT = 3'd3,
        ST_ERR_STOP  = 3'd4
    } state_e;

    localparam logic [STEP_W-1:0] INIT_FIRST = 4'd0;
    localparam logic [STEP_W-1:0] POLL_FIRST = 4'd6;
    localparam logic [STEP_W-1:0] LAST       = 4'd15;

    typedef struct packed {
        op_e        op;
        logic [7:0] data;
        logic       is_last;
        logic       is_read;
    } step_t;

    // Only address and write bytes carry a meaningful slave ACK/NACK.
    function automatic logic op_can_nack(input op_e op);
        return (op == OP_START) || (op == OP_WRBYTE);
    endfunction

endpackage

// File: rtl/mag_seq_script.sv
// Combinational script ROM: step index -> bus op, data byte and step flags.
module mag_seq_script
    import mag_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h1E,
    parameter logic [7:0] CRA_VAL  = 8'h70,
    parameter logic [7:0] CRB_VAL  = 8'h20,
    parameter logic [7:0] MODE_VAL = 8'h00
) (
    input  logic [STEP_W-1:0] step,
    output step_t             entry
);

    always_comb begin : script_rom
        entry = '{OP_STOP, 8'h00, 1'b1, 1'b0};
        case (step)
            INIT_FIRST: entry = '{OP_START,   {DEV_ADDR, 1'b0}, 1'b0, 1'b0};
            4'd1:       entry = '{OP_WRBYTE,  8'h00,            1'b0, 1'b0};
            4'd2:       entry = '{OP_WRBYTE,  CRA_VAL,          1'b0, 1'b0};
            4'd3:       entry = '{OP_WRBYTE,  CRB_VAL,          1'b0, 1'b0};
            4'd4:       entry = '{OP_WRBYTE,  MODE_VAL,         1'b0, 1'b0};
            4'd5:       entry = '{OP_STOP,    8'h00,            1'b1, 1'b0};
            POLL_FIRST: entry = '{OP_START,   {DEV_ADDR, 1'b0}, 1'b0, 1'b0};
            4'd7:       entry = '{OP_WRBYTE,  8'h03,            1'b0, 1'b0};
            4'd8:       entry = '{OP_START,   {DEV_ADDR, 1'b1}, 1'b0, 1'b0};
            4'd9, 4'd10, 4'd11, 4'd12, 4'd13:
                        entry = '{OP_RD_ACK,  8'h00,            1'b0, 1'b1};
            4'd14:      entry = '{OP_RD_NACK, 8'h00,            1'b0, 1'b1};
            LAST:       entry = '{OP_STOP,    8'h00,            1'b1, 1'b0};
            default:    entry = '{OP_STOP,    8'h00,            1'b1, 1'b0};
        endcase
    end

endmodule

// File: rtl/magnetometer_poll_sequencer.sv
// Configures an HMC5883L-class magnetometer once, then polls X/Z/Y through an I2C byte master.
// Optional response watchdog enabled by defining MAG_SEQ_TIMEOUT_EN.
module magnetometer_poll_sequencer
    import mag_seq_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h1E,
    parameter int unsigned POLL_DIV = 20000,
    parameter logic [7:0]  CRA_VAL  = 8'h70,
    parameter logic [7:0]  CRB_VAL  = 8'h20,
    parameter logic [7:0]  MODE_VAL = 8'h00
`ifdef MAG_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 5000
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic [31:0] mag_x,
    output logic [31:0] mag_y,
    output logic [31:0] mag_z,
    output logic        mag_valid,
    output logic        init_done,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int unsigned PW = $clog2(POLL_DIV + 1);
`ifdef MAG_SEQ_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt, wd_d;
`endif

    state_e            state, state_d;
    logic [STEP_W-1:0] step, step_d;
    logic              wait_rsp, wait_d;
    logic              cmd_valid_d;
    op_e               op_q, op_d;
    logic [7:0]        data_d;
    logic [PW-1:0]     poll_cnt, poll_cnt_d;
    logic [47:0]       bytes_q, bytes_d;
    logic [7:0]        err_d;
    logic              init_done_d, mag_upd;
    logic              busy_d, mag_valid_d;
    logic [31:0]       mag_x_d, mag_y_d, mag_z_d;
    step_t             cur;

    mag_seq_script #(
        .DEV_ADDR (DEV_ADDR),
        .CRA_VAL  (CRA_VAL),
        .CRB_VAL  (CRB_VAL),
        .MODE_VAL (MODE_VAL)
    ) u_script (
        .step  (step),
        .entry (cur)
    );

    assign cmd_op = op_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            step      <= INIT_FIRST;
            wait_rsp  <= 1'b0;
            cmd_valid <= 1'b0;
            op_q      <= OP_START;
            cmd_data  <= 8'h00;
            poll_cnt  <= '0;
            bytes_q   <= '0;
            err_count <= 8'h00;
            init_done <= 1'b0;
            busy      <= 1'b0;
            mag_valid <= 1'b0;
            mag_x     <= '0;
            mag_y     <= '0;
            mag_z     <= '0;
`ifdef MAG_SEQ_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            state     <= state_d;
            step      <= step_d;
            wait_rsp  <= wait_d;
            cmd_valid <= cmd_valid_d;
            op_q      <= op_d;
            cmd_data  <= data_d;
            poll_cnt  <= poll_cnt_d;
            bytes_q   <= bytes_d;
            err_count <= err_d;
            init_done <= init_done_d;
            busy      <= busy_d;
            mag_valid <= mag_valid_d;
            mag_x     <= mag_x_d;
            mag_y     <= mag_y_d;
            mag_z     <= mag_z_d;
`ifdef MAG_SEQ_TIMEOUT_EN
            wd_cnt    <= wd_d;
`endif
        end
    end

    // Script stepping, handshake, poll timer and error handling.
    always_comb begin : next_state
        logic err_hit;
        err_hit     = 1'b0;
        state_d     = state;
        step_d      = step;
        wait_d      = wait_rsp;
        cmd_valid_d = cmd_valid;
        op_d        = op_q;
        data_d      = cmd_data;
        poll_cnt_d  = poll_cnt;
        bytes_d     = bytes_q;
        init_done_d = init_done;
        mag_upd     = 1'b0;
`ifdef MAG_SEQ_TIMEOUT_EN
        wd_d        = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_d = init_done ? ST_RUN_POLL : ST_RUN_INIT;
                    step_d  = init_done ? POLL_FIRST : INIT_FIRST;
                end
            end
            ST_POLL_WAIT: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    poll_cnt_d = '0;
                end else if (poll_cnt == PW'(POLL_DIV - 1)) begin
                    poll_cnt_d = '0;
                    state_d    = init_done ? ST_RUN_POLL : ST_RUN_INIT;
                    step_d     = init_done ? POLL_FIRST : INIT_FIRST;
                end else begin
                    poll_cnt_d = poll_cnt + PW'(1);
                end
            end
            default: begin
                if (!cmd_valid && !wait_rsp) begin
                    cmd_valid_d = 1'b1;
                    op_d        = (state == ST_ERR_STOP) ? OP_STOP : cur.op;
                    data_d      = (state == ST_ERR_STOP) ? 8'h00 : cur.data;
                end else if (cmd_valid) begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        wait_d      = 1'b1;
                    end
                end else if (rsp_valid) begin
                    wait_d = 1'b0;
                    if (state != ST_ERR_STOP && op_can_nack(op_q) && rsp_nack) begin
                        err_hit = 1'b1;
                        state_d = ST_ERR_STOP;
                    end else if (state == ST_ERR_STOP || cur.is_last) begin
                        state_d = enable ? ST_POLL_WAIT : ST_IDLE;
                        if (state == ST_RUN_INIT) init_done_d = 1'b1;
                        if (state == ST_RUN_POLL) mag_upd = 1'b1;
                    end else begin
                        if (cur.is_read) bytes_d = {bytes_q[39:0], rsp_data};
                        step_d = step + STEP_W'(1);
                    end
`ifdef MAG_SEQ_TIMEOUT_EN
                end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
                    // Abandon the op; a lost STOP is not re-issued.
                    err_hit = 1'b1;
                    wait_d  = 1'b0;
                    if (state == ST_ERR_STOP || op_q == OP_STOP)
                        state_d = enable ? ST_POLL_WAIT : ST_IDLE;
                    else
                        state_d = ST_ERR_STOP;
                end else begin
                    wd_d = wd_cnt + WW'(1);
`endif
                end
            end
        endcase
        err_d = (err_hit && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end

    // Registered status and sample outputs; bytes arrive XH XL ZH ZL YH YL.
    always_comb begin : out_logic
        busy_d      = (state_d == ST_RUN_INIT) || (state_d == ST_RUN_POLL) ||
                      (state_d == ST_ERR_STOP);
        mag_valid_d = mag_upd;
        mag_x_d     = mag_x;
        mag_y_d     = mag_y;
        mag_z_d     = mag_z;
        if (mag_upd) begin
            mag_x_d = {{16{bytes_q[47]}}, bytes_q[47:32]};
            mag_z_d = {{16{bytes_q[31]}}, bytes_q[31:16]};
            mag_y_d = {{16{bytes_q[15]}}, bytes_q[15:0]};
        end
    end

endmodule
